// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage data-memory access unit.
//
// Turns EX_MEM load/store controls into a req/ack transaction on a
// variable-latency data memory. It generates byte enables and store lane
// replication, and sign/zero-extends load data. The pipeline is stalled
// until the access completes.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), async active-low reset
//   start_i              pipeline enable; low blocks new accesses
//   MemRead_i/MemWrite_i load/store request (both high = store)
//   funct3_i             access size/sign (b, h, w, bu, hu)
//   addr_i, wdata_i      byte address and store data
//   mem_req_o..wdata_o   memory request side, held stable while busy
//   mem_ack_i, rdata_i   one-cycle completion strobe and read word
//   stall_o              freezes the upstream pipeline registers
//   read_data_o          extended load data to MEM_WB
//   misalign_o           misaligned-access flag
//
// Optional feature: define MISALIGN_TRAP_EN to detect misaligned halfword
// and word accesses and complete them without touching memory. Without
// it, the low address bits are ignored (forced alignment).
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              stall_o,
    output logic [31:0]       read_data_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              stall_c;
    logic              accept;
    logic              mis;

    logic [3:0]        be_n;
    logic [31:0]       wdata_n;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [31:0]       ld_ext;

    assign accept = start_i & (MemRead_i | MemWrite_i);

`ifdef MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign mis = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                 (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    assign misalign_o = mis_q;
`else
    assign mis        = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // Store-side byte enables and lane replication from the incoming request.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_n    = 4'b0001 << addr_i[1:0];
                wdata_n = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_n = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and extension, using the offset/size latched at accept.
    always_comb begin
        ld_b   = mem_rdata_i[8*off_q +: 8];
        ld_h   = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ld_ext = mem_rdata_i;
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_ext = {24'd0, ld_b};
            3'b101:  ld_ext = {16'd0, ld_h};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        stall_c = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall_c = 1'b1;
                    if (mis) begin
                        // Trap path: skip memory, flag in DONE.
                        state_d = DONE;
`ifdef MISALIGN_TRAP_EN
                        mis_d   = 1'b1;
`endif
                    end else begin
                        state_d = BUSY;
                        we_d    = MemWrite_i;
                        addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        be_d    = be_n;
                        wdata_d = wdata_n;
                        f3_d    = funct3_i;
                        off_d   = addr_i[1:0];
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (mem_ack_i) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = ld_ext;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end
`endif

    // Request comes straight from the state register so reset drops it at once.
    assign mem_req_o   = (state_q == BUSY);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign read_data_o = rdata_q;
    // Keep the pipeline free while reset is held, whatever the inputs show.
    assign stall_o     = rst_i & stall_c;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, MemRead_i, MemWrite_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [31:0] read_data_o;
    logic        misalign_o;

    int nchecks = 0;
    int nerr    = 0;
    logic [31:0] last_rd;   // model: last completed load value

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .read_data_o(read_data_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model, computed arithmetically from the access rules.
    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int o = int'(a % 4);
        if (f3 == 3'b000 || f3 == 3'b100) return 4'(1 << o);
        if (f3 == 3'b001 || f3 == 3'b101) return 4'(3 << ((o / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] w);
        if (f3[1:0] == 2'b00) return (w % 256) * 32'h01010101;
        if (f3[1:0] == 2'b01) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        int unsigned o = a % 4;
        int unsigned b = (r / (32'd1 << (8 * o))) % 256;
        int unsigned h = (r / (32'd1 << (16 * (o / 2)))) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return r;
        endcase
    endfunction

    task automatic idle_cycle();
        @(negedge clk_i);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        start_i    = 1'($urandom);
        mem_ack_i  = 1'($urandom);   // stray ack in IDLE must be ignored
        #1;
        chk("idle_stall", 32'(stall_o), 32'd0);
        chk("idle_req", 32'(mem_req_o), 32'd0);
        chk("idle_misalign", 32'(misalign_o), 32'd0);
        chk("idle_rdata", read_data_o, last_rd);
    endtask

    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int lat);
        int nstall;
        @(negedge clk_i);
        start_i = 1'b1; MemRead_i = rd; MemWrite_i = wr;
        funct3_i = f3; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
        #1;
        chk("accept_stall", 32'(stall_o), 32'd1);
        chk("accept_req", 32'(mem_req_o), 32'd0);
        nstall = 1;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk_i);
            chk("busy_req", 32'(mem_req_o), 32'd1);
            chk("busy_addr", mem_addr_o, a & ~32'd3);
            chk("busy_we", 32'(mem_we_o), 32'(wr));
            chk("busy_be", 32'(mem_be_o), 32'(exp_be(f3, a)));
            if (wr) chk("busy_wdata", mem_wdata_o, exp_wd(f3, wd));
            chk("busy_misalign", 32'(misalign_o), 32'd0);
            if (stall_o) nstall++;
            start_i     = 1'($urandom);   // ignored while busy
            mem_ack_i   = (c == lat);
            mem_rdata_i = (c == lat) ? rdat : $urandom;
        end
        @(negedge clk_i);
        if (!wr) last_rd = exp_ld(f3, a, rdat);
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_req", 32'(mem_req_o), 32'd0);
        chk("done_rdata", read_data_o, last_rd);
        chk("stall_cycles", 32'(nstall), 32'(lat + 1));
        mem_ack_i = 1'($urandom);   // ack in DONE must be ignored
        idle_cycle();
    endtask

    initial begin
        int lat;
        logic [2:0] f3;
        logic [31:0] a;
        logic [2:0] f3tab [8];
        f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        last_rd = 32'd0;
        rst_i = 1'b0; start_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        funct3_i = 3'b010; addr_i = 32'h40; wdata_i = 32'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        repeat (3) @(negedge clk_i);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_rdata", read_data_o, 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        MemRead_i = 1'b0;
        rst_i = 1'b1;
        idle_cycle();
        chk("post_rst_be", 32'(mem_be_o), 32'd0);

        // Non-memory and start-gated cycles: no stall, no request.
        @(negedge clk_i);
        start_i = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b1; #1;
        chk("gated_stall", 32'(stall_o), 32'd0);
        idle_cycle();

        // Directed cases.
        access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 3);
        access(0, 1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1);
        chk("sb_be", 32'(exp_be(3'b000, 32'h203)), 32'h8);
        access(1, 0, 3'b000, 32'h301, 32'h0, 32'h00008000, 2);
        chk("lb_val", read_data_o, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h301, 32'h0, 32'h00008000, 1);
        chk("lbu_val", read_data_o, 32'h00000080);
        access(1, 0, 3'b101, 32'h302, 32'h0, 32'hBEEF0000, 4);
        chk("lhu_val", read_data_o, 32'h0000BEEF);
        access(1, 1, 3'b001, 32'h402, 32'h1234CAFE, 32'h0, 2);  // both = store

        // Reset while BUSY: request drops at once, late ack ignored.
        @(negedge clk_i);
        start_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        funct3_i = 3'b010; addr_i = 32'h500;
        @(negedge clk_i);
        chk("mid_req_before", 32'(mem_req_o), 32'd1);
        rst_i = 1'b0; #1;
        chk("mid_req_async", 32'(mem_req_o), 32'd0);
        chk("mid_stall", 32'(stall_o), 32'd0);
        last_rd = 32'd0;
        MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        chk("late_ack_req", 32'(mem_req_o), 32'd0);
        chk("late_ack_rdata", read_data_o, 32'd0);
        idle_cycle();

`ifdef MISALIGN_TRAP_EN
        @(negedge clk_i);
        start_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        funct3_i = 3'b010; addr_i = 32'h102; #1;
        chk("mis_stall", 32'(stall_o), 32'd1);
        chk("mis_req0", 32'(mem_req_o), 32'd0);
        @(negedge clk_i);
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_stall_done", 32'(stall_o), 32'd0);
        chk("mis_req1", 32'(mem_req_o), 32'd0);
        chk("mis_rdata", read_data_o, last_rd);
        idle_cycle();
`endif

        // Randomized accesses against the model.
        for (int i = 0; i < 60; i++) begin
            f3  = f3tab[$urandom_range(7)];
            a   = $urandom;
`ifdef MISALIGN_TRAP_EN
            a   = a & ~32'd3;
`endif
            lat = $urandom_range(1, 5);
            case ($urandom_range(2))
                0: access(1, 0, f3, a, $urandom, $urandom, lat);
                1: access(0, 1, f3, a, $urandom, $urandom, lat);
                default: idle_cycle();
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the 5-stage RISC-V pipeline, sitting between the EX_MEM register and the MEM_WB register. It converts load/store controls from EX_MEM into a req/ack transaction on a variable-latency data memory. It generates byte enables and load sign/zero extension, and stalls the pipeline until the access completes. Its `read_data_o` feeds the `read_data_i` input of MEM_WB.

## Interface
- `ADDR_W`, 32, data address width.
- `clk_i`  in  1  pipeline clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  pipeline enable; low blocks acceptance of new accesses.
- `MemRead_i`  in  1  load request from EX_MEM.
- `MemWrite_i`  in  1  store request from EX_MEM.
- `funct3_i`  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `addr_i`  in  ADDR_W  byte address (ALU result).
- `wdata_i`  in  32  store data (rs2).
- `mem_req_o`  out  1  memory request, held until ack.
- `mem_we_o`  out  1  1 = write.
- `mem_addr_o`  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- `mem_be_o`  out  4  byte enables.
- `mem_wdata_o`  out  32  lane-aligned store data.
- `mem_ack_i`  in  1  one-cycle completion strobe.
- `mem_rdata_i`  in  32  read word, valid with ack.
- `stall_o`  out  1  freeze PC, IF_ID, ID_EX and EX_MEM.
- `read_data_o`  out  32  extended load data to MEM_WB.
- `misalign_o`  out  1  misaligned-access flag; tied 0 unless the macro is defined.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - With `start_i` high and `MemRead_i|MemWrite_i` high, the access is accepted: `stall_o`=1 combinationally, request fields are registered, and the FSM moves to BUSY.
  - Otherwise `stall_o`=0 and the FSM stays in IDLE.
- BUSY:
  - `mem_req_o`=1 and `stall_o`=1.
  - `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` stay stable.
  - When `mem_ack_i` is sampled high, the FSM moves to DONE. On a load, the extended `mem_rdata_i` is captured into `read_data_o` at that edge.
  - `start_i` is ignored; the transaction is never abandoned.
- DONE:
  - `mem_req_o`=0 and `stall_o`=0, so the pipeline advances and MEM_WB captures `read_data_o`.
  - The FSM returns to IDLE unconditionally. The still-present EX_MEM inputs are never re-issued.
- `mem_ack_i` is ignored in IDLE and DONE.
- `MemRead_i` and `MemWrite_i` both high is treated as a store.
- Byte enables and store lanes, with o = `addr_i[1:0]`:
  - sb: `mem_be_o` = 4'b0001<<o; `mem_wdata_o` = the byte replicated ×4.
  - sh: `mem_be_o` = 4'b0011<<(2·o[1]); `mem_wdata_o` = the halfword replicated ×2.
  - sw, and any other funct3: `mem_be_o` = 4'b1111.
- Loads:
  - Select byte o, or halfword o[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw and any other funct3 pass the full word.
- `read_data_o` holds its last load value through stores and non-memory instructions.
- Misalignment without the macro: low bits are ignored, i.e. forced alignment. Halfwords use o[1] only; words use bits [ADDR_W-1:2].

## Timing
- Reset values: `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_be_o`=0, `mem_wdata_o`=0, `read_data_o`=0, `misalign_o`=0. `stall_o`=0 while in reset.
- Non-memory instruction: 0 stall cycles.
- Memory access latency:
  - Cycle 0: accept (IDLE).
  - Cycle 1: first `mem_req_o`.
  - Ack in cycle n≥1: DONE in cycle n+1.
  - Total stall = n+1 cycles; minimum 2 stall cycles, 3 cycles of MEM occupancy.
- `mem_req_o` deasserts the cycle after the ack cycle.
- Reset mid-transaction: the FSM returns to IDLE and `mem_req_o` drops immediately and asynchronously. A late ack after reset is ignored.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are detected in IDLE: halfword with o[0]=1, or word with o≠0.
  - Such an access goes IDLE→DONE directly, with `stall_o`=1 for one cycle and no memory request.
  - `misalign_o`=1 for the DONE cycle; `read_data_o` is unchanged.
- `MISALIGN_TRAP_EN` undefined:
  - Forced alignment as described in Operation.
  - `misalign_o` is constant 0 and no detection logic is present.

## Test plan
- Reset, then `rst_i` released with no access → all outputs 0, `stall_o`=0, FSM in IDLE.
- sw addr=0x104, wdata=0xDEADBEEF, ack 3 cycles after req → `mem_addr_o`=0x104, `mem_be_o`=4'b1111, `mem_we_o`=1; `stall_o` high for 4 cycles then low for one DONE cycle.
- sb addr=0x203, wdata=0x000000A5, ack immediate → `mem_be_o`=4'b1000, `mem_wdata_o`=0xA5A5A5A5, `mem_addr_o`=0x200.
- lb addr=0x301, rdata=0x00008000 → `read_data_o`=0xFFFFFF80. Same access as lbu → 0x00000080. lhu addr=0x302, rdata=0xBEEF0000 → 0x0000BEEF.
- Reset asserted in BUSY, then ack pulses → `mem_req_o` drops immediately, ack ignored, FSM in IDLE, `read_data_o`=0.
- With `MISALIGN_TRAP_EN`: lw addr=0x102 → no `mem_req_o`; `stall_o` high for 1 cycle, then `misalign_o`=1 for 1 cycle.
